xover_i2s_tx: RTL and testbench

//  Sink end of the crossover sample path: takes LPF/HPF outputs of the left and right crossover

---
 rtl/xover_i2s_tx_pkg.sv | 18 +
 rtl/xover_i2s_lane.sv | 41 ++++
 rtl/xover_i2s_tx.sv | 115 +++++++++++
 tb/tb_xover_i2s_tx.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xover_i2s_tx_pkg.sv
// Shared constants for the crossover I2S transmitter: sample width, slot width, clock ratios.
package xover_i2s_tx_pkg;

  localparam int c_DATA_NBITS     = 24;
  localparam int c_I2S_SLOT_NBITS = 32;
  localparam int c_MCK_PER_FS     = 256;
  localparam int c_MCK_PER_BCK    = 4;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  function automatic int frame_cnt_nbits(input int slot_nbits);
    return $clog2(c_MCK_PER_BCK * 2 * slot_nbits);
  endfunction

endpackage

// File: rtl/xover_i2s_lane.sv
// One I2S data lane: left/right frame registers and the registered slot-bit mux.
module xover_i2s_lane
  import xover_i2s_tx_pkg::*;
#(
  parameter int DATA_NBITS = c_DATA_NBITS,
  parameter int SLOT_NBITS = c_I2S_SLOT_NBITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_l,
  input  logic                          load_r,
  input  logic [DATA_NBITS-1:0]         data_l,
  input  logic [DATA_NBITS-1:0]         data_r,
  input  chan_e                         chan_n,
  input  logic [$clog2(SLOT_NBITS)-1:0] pos_n,
  output logic                          sdata
);

  logic [DATA_NBITS-1:0] frame_l;
  logic [DATA_NBITS-1:0] frame_r;
  logic [0:SLOT_NBITS-1] slot;

  // Slot position 0 is the one-BCK I2S delay; positions past the LSB pad with zeros.
  always_comb begin
    slot = '0;
    slot[1 +: DATA_NBITS] = (chan_n == CH_RIGHT) ? frame_r : frame_l;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_l <= '0;
      frame_r <= '0;
      sdata   <= 1'b0;
    end else begin
      if (load_l) frame_l <= data_l;
      if (load_r) frame_r <= data_r;
      sdata <= slot[pos_n];
    end
  end

endmodule

// File: rtl/xover_i2s_tx.sv
// Crossover sink: double-buffers LPF/HPF L/R samples and serialises them on two I2S lanes.
// Build option XOVER_TX_UNDERRUN_MUTE_EN: a stale channel is muted instead of repeated.
module xover_i2s_tx
  import xover_i2s_tx_pkg::*;
#(
  parameter int DATA_NBITS = c_DATA_NBITS,
  parameter int SLOT_NBITS = c_I2S_SLOT_NBITS
) (
  input  logic                  i_mck,
  input  logic                  i_rst,
  input  logic [DATA_NBITS-1:0] i_lpf_l,
  input  logic [DATA_NBITS-1:0] i_hpf_l,
  input  logic                  i_valid_l,
  input  logic [DATA_NBITS-1:0] i_lpf_r,
  input  logic [DATA_NBITS-1:0] i_hpf_r,
  input  logic                  i_valid_r,
  output logic                  o_bck,
  output logic                  o_lrck,
  output logic                  o_sdata_lo,
  output logic                  o_sdata_hi,
  output logic                  o_underrun,
  output logic                  o_overrun
);

  localparam int CNT_NBITS = frame_cnt_nbits(SLOT_NBITS);

  logic [CNT_NBITS-1:0]  cnt;
  logic [CNT_NBITS-1:0]  cnt_next;
  logic                  load;
  logic [DATA_NBITS-1:0] pend_lpf_l, pend_hpf_l, pend_lpf_r, pend_hpf_r;
  logic                  fresh_l, fresh_r;
  logic                  load_l, load_r;
  logic [DATA_NBITS-1:0] ld_lpf_l, ld_hpf_l, ld_lpf_r, ld_hpf_r;
  chan_e                 chan_n;

  assign cnt_next = cnt + 1'b1;
  assign load     = (cnt == '1);
  assign chan_n   = chan_e'(cnt_next[CNT_NBITS-1]);

  always_ff @(posedge i_mck or posedge i_rst) begin
    if (i_rst) begin
      cnt        <= '0;
      o_bck      <= 1'b0;
      o_lrck     <= 1'b0;
      o_underrun <= 1'b0;
      o_overrun  <= 1'b0;
      pend_lpf_l <= '0;
      pend_hpf_l <= '0;
      pend_lpf_r <= '0;
      pend_hpf_r <= '0;
      fresh_l    <= 1'b0;
      fresh_r    <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      o_bck      <= cnt_next[1];
      o_lrck     <= cnt_next[CNT_NBITS-1];
      o_underrun <= load & ~(fresh_l & fresh_r);
      o_overrun  <= ~load & ((i_valid_l & fresh_l) | (i_valid_r & fresh_r));
      if (i_valid_l) begin
        pend_lpf_l <= i_lpf_l;
        pend_hpf_l <= i_hpf_l;
      end
      if (i_valid_r) begin
        pend_lpf_r <= i_lpf_r;
        pend_hpf_r <= i_hpf_r;
      end
      // A valid in the load cycle keeps fresh set so it counts toward the next frame.
      if (i_valid_l)  fresh_l <= 1'b1;
      else if (load)  fresh_l <= 1'b0;
      if (i_valid_r)  fresh_r <= 1'b1;
      else if (load)  fresh_r <= 1'b0;
    end
  end

`ifdef XOVER_TX_UNDERRUN_MUTE_EN
  assign load_l   = load;
  assign load_r   = load;
  assign ld_lpf_l = fresh_l ? pend_lpf_l : '0;
  assign ld_hpf_l = fresh_l ? pend_hpf_l : '0;
  assign ld_lpf_r = fresh_r ? pend_lpf_r : '0;
  assign ld_hpf_r = fresh_r ? pend_hpf_r : '0;
`else
  assign load_l   = load & fresh_l;
  assign load_r   = load & fresh_r;
  assign ld_lpf_l = pend_lpf_l;
  assign ld_hpf_l = pend_hpf_l;
  assign ld_lpf_r = pend_lpf_r;
  assign ld_hpf_r = pend_hpf_r;
`endif

  xover_i2s_lane #(.DATA_NBITS(DATA_NBITS), .SLOT_NBITS(SLOT_NBITS)) u_lane_lo (
    .clk    (i_mck),
    .rst    (i_rst),
    .load_l (load_l),
    .load_r (load_r),
    .data_l (ld_lpf_l),
    .data_r (ld_lpf_r),
    .chan_n (chan_n),
    .pos_n  (cnt_next[CNT_NBITS-2:2]),
    .sdata  (o_sdata_lo)
  );

  xover_i2s_lane #(.DATA_NBITS(DATA_NBITS), .SLOT_NBITS(SLOT_NBITS)) u_lane_hi (
    .clk    (i_mck),
    .rst    (i_rst),
    .load_l (load_l),
    .load_r (load_r),
    .data_l (ld_hpf_l),
    .data_r (ld_hpf_r),
    .chan_n (chan_n),
    .pos_n  (cnt_next[CNT_NBITS-2:2]),
    .sdata  (o_sdata_hi)
  );

endmodule

// File: tb/tb_xover_i2s_tx.sv
// Scoreboard bench for xover_i2s_tx: frame-level reference model vs. an I2S deserialising monitor.
module tb_xover_i2s_tx;
  import xover_i2s_tx_pkg::*;

  localparam int DW = c_DATA_NBITS;
  localparam int SW = c_I2S_SLOT_NBITS;

  logic          i_mck = 1'b0;
  logic          i_rst;
  logic [DW-1:0] i_lpf_l, i_hpf_l, i_lpf_r, i_hpf_r;
  logic          i_valid_l, i_valid_r;
  logic          o_bck, o_lrck, o_sdata_lo, o_sdata_hi, o_underrun, o_overrun;

  always #5 i_mck = ~i_mck;

  xover_i2s_tx dut (
    .i_mck      (i_mck),
    .i_rst      (i_rst),
    .i_lpf_l    (i_lpf_l),
    .i_hpf_l    (i_hpf_l),
    .i_valid_l  (i_valid_l),
    .i_lpf_r    (i_lpf_r),
    .i_hpf_r    (i_hpf_r),
    .i_valid_r  (i_valid_r),
    .o_bck      (o_bck),
    .o_lrck     (o_lrck),
    .o_sdata_lo (o_sdata_lo),
    .o_sdata_hi (o_sdata_hi),
    .o_underrun (o_underrun),
    .o_overrun  (o_overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit            vl;
    bit            vr;
    logic [DW-1:0] lpf_l, hpf_l, lpf_r, hpf_r;
  } cyc_t;

  typedef struct {
    logic [DW-1:0] lo_l, lo_r, hi_l, hi_r;
    int            und;
    int            ovr;
  } exp_t;

  cyc_t          plan [256];
  cyc_t          carry;
  exp_t          nxt;
  exp_t          sb [$];
  logic [DW-1:0] sent_lpf_l, sent_hpf_l, sent_lpf_r, sent_hpf_r;

  function automatic logic [31:0] slotw(input logic [DW-1:0] d);
    return {1'b0, d, {(SW-DW-1){1'b0}}};
  endfunction

  task automatic reset_model();
    sent_lpf_l = '0; sent_hpf_l = '0; sent_lpf_r = '0; sent_hpf_r = '0;
    carry.vl = 1'b0; carry.vr = 1'b0;
    carry.lpf_l = '0; carry.hpf_l = '0; carry.lpf_r = '0; carry.hpf_r = '0;
    nxt.lo_l = '0; nxt.lo_r = '0; nxt.hi_l = '0; nxt.hi_r = '0;
    nxt.und = 0; nxt.ovr = 0;
    sb.delete();
  endtask

  task automatic clear_plan();
    for (int c = 0; c < 256; c++) begin
      plan[c].vl    = 1'b0;
      plan[c].vr    = 1'b0;
      plan[c].lpf_l = DW'($urandom);
      plan[c].hpf_l = DW'($urandom);
      plan[c].lpf_r = DW'($urandom);
      plan[c].hpf_r = DW'($urandom);
    end
  endtask

  task automatic add_l(input int c, input logic [DW-1:0] lpf, input logic [DW-1:0] hpf);
    plan[c].vl = 1'b1; plan[c].lpf_l = lpf; plan[c].hpf_l = hpf;
  endtask

  task automatic add_r(input int c, input logic [DW-1:0] lpf, input logic [DW-1:0] hpf);
    plan[c].vr = 1'b1; plan[c].lpf_r = lpf; plan[c].hpf_r = hpf;
  endtask

  task automatic rand_plan();
    int n;
    clear_plan();
    n = $urandom_range(0, 3);
    for (int k = 0; k < n; k++) add_l($urandom_range(0, 240), DW'($urandom), DW'($urandom));
    n = $urandom_range(0, 3);
    for (int k = 0; k < n; k++) add_r($urandom_range(0, 240), DW'($urandom), DW'($urandom));
    if ($urandom_range(0, 5) == 0) add_l(255, DW'($urandom), DW'($urandom));
    if ($urandom_range(0, 5) == 0) add_r(255, DW'($urandom), DW'($urandom));
  endtask

  // Frame-level model. The window feeding a load is the previous frame's load-cycle
  // valid plus this frame's valids before the load cycle; the last one in it wins.
  task automatic model_frame();
    exp_t          cur;
    int            nl, nr, ov;
    bit            dup;
    logic [DW-1:0] ll, lh, rl, rh;
    cur = nxt;
    nl = carry.vl ? 1 : 0;
    nr = carry.vr ? 1 : 0;
    ll = carry.lpf_l; lh = carry.hpf_l; rl = carry.lpf_r; rh = carry.hpf_r;
    ov = 0;
    for (int c = 0; c < 255; c++) begin
      dup = 1'b0;
      if (plan[c].vl) begin
        nl++;
        if (nl > 1) dup = 1'b1;
        ll = plan[c].lpf_l; lh = plan[c].hpf_l;
      end
      if (plan[c].vr) begin
        nr++;
        if (nr > 1) dup = 1'b1;
        rl = plan[c].lpf_r; rh = plan[c].hpf_r;
      end
      if (dup) ov++;
    end
    cur.ovr = ov;
    sb.push_back(cur);
    if (nl > 0) begin
      sent_lpf_l = ll; sent_hpf_l = lh;
    end
`ifdef XOVER_TX_UNDERRUN_MUTE_EN
    else begin
      sent_lpf_l = '0; sent_hpf_l = '0;
    end
`endif
    if (nr > 0) begin
      sent_lpf_r = rl; sent_hpf_r = rh;
    end
`ifdef XOVER_TX_UNDERRUN_MUTE_EN
    else begin
      sent_lpf_r = '0; sent_hpf_r = '0;
    end
`endif
    nxt.lo_l = sent_lpf_l; nxt.hi_l = sent_hpf_l;
    nxt.lo_r = sent_lpf_r; nxt.hi_r = sent_hpf_r;
    nxt.und  = (nl == 0 || nr == 0) ? 1 : 0;
    nxt.ovr  = 0;
    carry = plan[255];
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_bck"},      32'(o_bck),      32'd0);
    chk({tag, "_lrck"},     32'(o_lrck),     32'd0);
    chk({tag, "_sdata_lo"}, 32'(o_sdata_lo), 32'd0);
    chk({tag, "_sdata_hi"}, 32'(o_sdata_hi), 32'd0);
    chk({tag, "_underrun"}, 32'(o_underrun), 32'd0);
    chk({tag, "_overrun"},  32'(o_overrun),  32'd0);
  endtask

  // Loop index c equals the DUT counter value of the current mck cycle.
  task automatic run_frame(input int abort_at);
    model_frame();
    for (int c = 0; c < 256; c++) begin
      i_valid_l = plan[c].vl; i_valid_r = plan[c].vr;
      i_lpf_l = plan[c].lpf_l; i_hpf_l = plan[c].hpf_l;
      i_lpf_r = plan[c].lpf_r; i_hpf_r = plan[c].hpf_r;
      if (c == abort_at) begin
        chk("bck_before_reset", 32'(o_bck), 32'd1);
        #2 i_rst = 1'b1;
        #1 check_outputs_zero("mid_reset");
        i_valid_l = 1'b0; i_valid_r = 1'b0;
        reset_model();
        repeat (2) @(posedge i_mck);
        #1 i_rst = 1'b0;
        return;
      end
      @(posedge i_mck);
      #1;
    end
    i_valid_l = 1'b0; i_valid_r = 1'b0;
  endtask

  // Monitor: deserialises both lanes on BCK rising edges and checks clock periods.
  bit          prev_bck, prev_lrck, bck_seen, lrck_seen, slot_lr, have_left;
  int          bck_run, lrck_run, bitn, und_cnt, ovr_cnt, frames_seen;
  logic [31:0] word_lo, word_hi, left_lo, left_hi;
  exp_t        e;

  always @(negedge i_mck) begin
    if (i_rst) begin
      prev_bck = 1'b0; prev_lrck = 1'b0; bck_seen = 1'b0; lrck_seen = 1'b0;
      bck_run = 0; lrck_run = 0; bitn = 0; slot_lr = 1'b0; have_left = 1'b0;
      und_cnt = 0; ovr_cnt = 0; word_lo = '0; word_hi = '0;
    end else begin
      if (o_bck != prev_bck) begin
        if (bck_seen) chk("bck_half_period", 32'(bck_run), 32'd2);
        bck_seen = 1'b1; bck_run = 1;
      end else bck_run++;
      if (o_lrck != prev_lrck) begin
        if (lrck_seen) chk("lrck_half_period", 32'(lrck_run), 32'd128);
        lrck_seen = 1'b1; lrck_run = 1;
      end else lrck_run++;
      if (o_underrun) und_cnt++;
      if (o_overrun)  ovr_cnt++;
      if (o_bck && !prev_bck) begin
        if (o_lrck != slot_lr) begin
          bitn = 0; slot_lr = o_lrck;
        end
        word_lo = {word_lo[30:0], o_sdata_lo};
        word_hi = {word_hi[30:0], o_sdata_hi};
        bitn++;
        if (bitn == SW) begin
          bitn = 0;
          if (!slot_lr) begin
            left_lo = word_lo; left_hi = word_hi; have_left = 1'b1;
          end else if (have_left) begin
            have_left = 1'b0;
            if (sb.size() == 0) begin
              n_checks++; n_errors++;
              $display("FAIL sb_empty: frame %0d seen, no expected entry", frames_seen);
            end else begin
              e = sb.pop_front();
              chk($sformatf("f%0d_lo_left", frames_seen),  left_lo, slotw(e.lo_l));
              chk($sformatf("f%0d_hi_left", frames_seen),  left_hi, slotw(e.hi_l));
              chk($sformatf("f%0d_lo_right", frames_seen), word_lo, slotw(e.lo_r));
              chk($sformatf("f%0d_hi_right", frames_seen), word_hi, slotw(e.hi_r));
              chk($sformatf("f%0d_underrun", frames_seen), 32'(und_cnt), 32'(e.und));
              chk($sformatf("f%0d_overrun", frames_seen),  32'(ovr_cnt), 32'(e.ovr));
            end
            frames_seen++;
            und_cnt = 0; ovr_cnt = 0;
          end
        end
      end
      prev_bck = o_bck; prev_lrck = o_lrck;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frames_seen = 0;
    i_rst = 1'b1;
    i_valid_l = 1'b0; i_valid_r = 1'b0;
    i_lpf_l = '0; i_hpf_l = '0; i_lpf_r = '0; i_hpf_r = '0;
    reset_model();
    repeat (3) @(posedge i_mck);
    #1 check_outputs_zero("reset");
    i_rst = 1'b0;

    // Frame 0 (sent as zeros) carries the reference vectors into frame 1.
    clear_plan();
    add_l(100, 24'h800001, 24'h123456);
    add_r(100, 24'h0A0B0C, 24'h7FFFFE);
    run_frame(-1);
    // No valids: frame 2 is stale (muted or repeated).
    clear_plan();
    run_frame(-1);
    // Two left valids 10 clks apart: one overrun, second sample sent.
    clear_plan();
    add_l(50, 24'h111111, 24'h222222);
    add_l(60, 24'h333333, 24'h444444);
    add_r(70, 24'h555555, 24'h666666);
    run_frame(-1);
    // Right valid in the load cycle: old value next frame, new value the frame after.
    clear_plan();
    add_l(20, 24'h0F0F0F, 24'hF0F0F0);
    add_r(30, 24'hABCDEF, 24'hFEDCBA);
    add_r(255, 24'h13579B, 24'h2468AC);
    run_frame(-1);
    clear_plan();
    add_l(40, 24'h765432, 24'h89ABCD);
    run_frame(-1);
    clear_plan();
    add_l(10, 24'hFFFFFF, 24'h000001);
    add_r(10, 24'h800000, 24'h7FFFFF);
    run_frame(-1);

    repeat (16) begin
      rand_plan();
      run_frame(-1);
    end

    // Reset at left-slot position 12 of a frame carrying nonzero data.
    clear_plan();
    add_l(5, 24'hC3C3C3, 24'h3C3C3C);
    add_r(5, 24'hA5A5A5, 24'h5A5A5A);
    run_frame(-1);
    rand_plan();
    run_frame(50);

    repeat (3) begin
      rand_plan();
      run_frame(-1);
    end
    clear_plan();
    run_frame(-1);
    repeat (4) @(posedge i_mck);

    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: %0d expected frames never seen, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
